// File: rtl/ddr3_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_sched_pkg
// Purpose  : Shared types, field widths and small helpers for the DDR3
//            command scheduler and its refresh timer.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_sched_pkg;

  // Command field widths presented to the DDR3 command state machine
  localparam int ROW_W  = 15;
  localparam int COL_W  = 10;
  localparam int BA_W   = 3;
  localparam int DATA_W = 8;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Kind of command currently in flight
  typedef enum logic [1:0] {
    KIND_RD  = 2'd0,
    KIND_WR  = 2'd1,
    KIND_REF = 2'd2
  } kind_t;

  // Round-robin pick between two requesters: on a tie the one that did not
  // win last time is chosen; otherwise the single valid one (0 when none).
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    if (valid == 2'b11) begin
      return ~last_grant;
    end
    return valid[1];
  endfunction

  // Requester index to one-hot pulse vector
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_refresh_timer
// Purpose  : Periodic auto-refresh request generator. A 16-bit down-counter
//            raises ref_pending every REFI_CYCLES clocks; ref_overrun latches
//            if an interval expires while the previous refresh is still owed.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_refresh_timer #(
  parameter int REFI_CYCLES = 780
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic ref_pending,
  output logic ref_overrun
);

  localparam logic [15:0] C_RELOAD = 16'(REFI_CYCLES - 1);

  logic [15:0] count;
  logic        expire;

  assign expire = (count == 16'd0);

  // Interval counter: counts down and reloads on reaching zero
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= C_RELOAD;
    end else if (expire) begin
      count <= C_RELOAD;
    end else begin
      count <= count - 16'd1;
    end
  end

  // Pending/overrun flags; a new expiry wins over a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
    end else if (expire) begin
      ref_pending <= 1'b1;
      if (ref_pending) begin
        ref_overrun <= 1'b1;
      end
    end else if (clear) begin
      ref_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr3_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_cmd_scheduler
// Purpose  : Round-robin scheduler for two single-beat read/write requesters
//            in front of the DDR3 command state machine, with periodic
//            auto-refresh injected at top priority.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_cmd_scheduler
  import ddr3_sched_pkg::*;
#(
  parameter int REFI_CYCLES = 780
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ROW_W-1:0]    req_row,
  input  logic [2*COL_W-1:0]    req_col,
  input  logic [2*BA_W-1:0]     req_ba,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  input  logic                  sm_ready,
  input  logic                  sm_done,
  input  logic [DATA_W-1:0]     sm_rdata,
  output logic                  WRITE,
  output logic                  READ,
  output logic                  REF,
  output logic [ROW_W-1:0]      Addr_Row,
  output logic [COL_W-1:0]      Addr_Column,
  output logic [BA_W-1:0]       BA_in,
  output logic [DATA_W-1:0]     Data_input,
  output logic                  ref_pending,
  output logic                  ref_overrun
);

  state_t state;
  kind_t  kind;
  logic   last_grant;
  logic   pick;
  logic   idle_ready;
  logic   take_ref;
  logic   take_req;
  logic   ref_clear;

  // Arbitration decisions, all made in the IDLE cycle
  assign idle_ready = (state == ST_IDLE) && sm_ready;
  assign take_ref   = idle_ready && ref_pending;
  assign take_req   = idle_ready && !ref_pending && (req_valid != 2'b00);
  assign pick       = rr_pick(req_valid, last_grant);

  // Accept pulse coincides with the grant cycle
  assign req_ready = take_req ? onehot2(pick) : 2'b00;

  // Command strobes last exactly the one ISSUE cycle
  assign WRITE = (state == ST_ISSUE) && (kind == KIND_WR);
  assign READ  = (state == ST_ISSUE) && (kind == KIND_RD);
  assign REF   = (state == ST_ISSUE) && (kind == KIND_REF);

  // Refresh grants never touch last_grant, so it still names the requester
  // whose transaction reaches RESP
  assign rsp_valid = (state == ST_RESP) ? onehot2(last_grant) : 2'b00;

  assign ref_clear = REF;

  ddr3_refresh_timer #(
    .REFI_CYCLES (REFI_CYCLES)
  ) u_refresh_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .clear       (ref_clear),
    .ref_pending (ref_pending),
    .ref_overrun (ref_overrun)
  );

  // Command sequencing: IDLE -> ISSUE -> WAIT -> (RESP) -> IDLE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      kind  <= KIND_RD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_ref) begin
            kind  <= KIND_REF;
            state <= ST_ISSUE;
          end else if (take_req) begin
            kind  <= req_write[pick] ? KIND_WR : KIND_RD;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sm_done) begin
            state <= (kind == KIND_REF) ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant bookkeeping and command field capture, only on a requester grant
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant  <= 1'b1;
      Addr_Row    <= '0;
      Addr_Column <= '0;
      BA_in       <= '0;
      Data_input  <= '0;
    end else if (take_req) begin
      last_grant  <= pick;
      Addr_Row    <= pick ? req_row[2*ROW_W-1:ROW_W]     : req_row[ROW_W-1:0];
      Addr_Column <= pick ? req_col[2*COL_W-1:COL_W]     : req_col[COL_W-1:0];
      BA_in       <= pick ? req_ba[2*BA_W-1:BA_W]        : req_ba[BA_W-1:0];
      Data_input  <= pick ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end
  end

  // Read data capture on completion of a requester command
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_rdata <= '0;
    end else if ((state == ST_WAIT) && sm_done && (kind != KIND_REF)) begin
      rsp_rdata <= sm_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_cmd_scheduler
// Purpose  : Self-checking bench. A long-interval instance runs a cycle-by-
//            cycle vector table; a 16-cycle-interval instance runs refresh
//            priority, overrun and set-versus-clear sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_cmd_scheduler;

  logic        clk;
  logic        RESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [29:0] req_row;
  logic [19:0] req_col;
  logic [5:0]  req_ba;
  logic [15:0] req_wdata;
  logic        sm_ready;
  logic        sm_done;
  logic [7:0]  sm_rdata;

  // Outputs of the long-interval instance
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        WRITE, READ, REF;
  logic [14:0] Addr_Row;
  logic [9:0]  Addr_Column;
  logic [2:0]  BA_in;
  logic [7:0]  Data_input;
  logic        ref_pending, ref_overrun;

  // Outputs of the 16-cycle-interval instance
  logic [1:0]  f_req_ready, f_rsp_valid;
  logic [7:0]  f_rsp_rdata;
  logic        f_WRITE, f_READ, f_REF;
  logic [14:0] f_Addr_Row;
  logic [9:0]  f_Addr_Column;
  logic [2:0]  f_BA_in;
  logic [7:0]  f_Data_input;
  logic        f_ref_pending, f_ref_overrun;

  // Fixed per-requester command fields
  localparam logic [14:0] R0_ROW = 15'h0001;
  localparam logic [9:0]  R0_COL = 10'h001;
  localparam logic [2:0]  R0_BA  = 3'h5;
  localparam logic [7:0]  R0_WD  = 8'hA5;
  localparam logic [14:0] R1_ROW = 15'h1234;
  localparam logic [9:0]  R1_COL = 10'h2AB;
  localparam logic [2:0]  R1_BA  = 3'h3;
  localparam logic [7:0]  R1_WD  = 8'h5A;

  assign req_row   = {R1_ROW, R0_ROW};
  assign req_col   = {R1_COL, R0_COL};
  assign req_ba    = {R1_BA,  R0_BA};
  assign req_wdata = {R1_WD,  R0_WD};

  ddr3_cmd_scheduler #(.REFI_CYCLES(1000)) u_dut (
    .CLK(clk), .RESET(RESET),
    .req_valid(req_valid), .req_write(req_write), .req_row(req_row),
    .req_col(req_col), .req_ba(req_ba), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sm_ready(sm_ready), .sm_done(sm_done), .sm_rdata(sm_rdata),
    .WRITE(WRITE), .READ(READ), .REF(REF),
    .Addr_Row(Addr_Row), .Addr_Column(Addr_Column), .BA_in(BA_in),
    .Data_input(Data_input), .ref_pending(ref_pending), .ref_overrun(ref_overrun)
  );

  ddr3_cmd_scheduler #(.REFI_CYCLES(16)) u_fast (
    .CLK(clk), .RESET(RESET),
    .req_valid(req_valid), .req_write(req_write), .req_row(req_row),
    .req_col(req_col), .req_ba(req_ba), .req_wdata(req_wdata),
    .req_ready(f_req_ready), .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
    .sm_ready(sm_ready), .sm_done(sm_done), .sm_rdata(sm_rdata),
    .WRITE(f_WRITE), .READ(f_READ), .REF(f_REF),
    .Addr_Row(f_Addr_Row), .Addr_Column(f_Addr_Column), .BA_in(f_BA_in),
    .Data_input(f_Data_input), .ref_pending(f_ref_pending), .ref_overrun(f_ref_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // fld: 0 = reset zeros, 1 = requester 0 fields, 2 = requester 1 fields
  function automatic logic [35:0] exp_fields(input logic [1:0] sel);
    case (sel)
      2'd1:    return {R0_ROW, R0_COL, R0_BA, R0_WD};
      2'd2:    return {R1_ROW, R1_COL, R1_BA, R1_WD};
      default: return 36'd0;
    endcase
  endfunction

  typedef struct packed {
    logic       rst;
    logic [1:0] valid;
    logic [1:0] wr;
    logic       rdy;
    logic       done;
    logic [7:0] rdata;
    logic       chk;    // compare outputs this cycle
    logic [1:0] e_rr;   // expected req_ready
    logic [2:0] e_stb;  // expected {WRITE, READ, REF}
    logic [1:0] e_rsp;  // expected rsp_valid
    logic [1:0] e_fld;  // expected field set
    logic       e_chkd; // compare rsp_rdata
    logic [7:0] e_rdata;
  } vec_t;

  localparam int NV = 44;
  vec_t vecs [NV];

  task automatic apply_idle_reset();
    @(negedge clk);
    RESET = 1'b1; req_valid = 2'b00; req_write = 2'b00;
    sm_ready = 1'b0; sm_done = 1'b0; sm_rdata = 8'h00;
  endtask

  int ref_cnt;

  initial begin
    RESET = 1'b1; req_valid = 2'b00; req_write = 2'b00;
    sm_ready = 1'b0; sm_done = 1'b0; sm_rdata = 8'h00;

    //            rst valid  wr    rdy   done  rdata  chk   rr     stb     rsp    fld   chkd  e_rdata
    // reset and single write to requester 0, sm_done three cycles after WRITE
    vecs[0]  = '{1'b1,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b0, 2'b00,3'b000,2'b00,2'd0, 1'b0,8'h00};
    vecs[1]  = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd0, 1'b1,8'h00};
    vecs[2]  = '{1'b0,2'b01,2'b01,1'b1,1'b0,8'h00, 1'b1, 2'b01,3'b000,2'b00,2'd0, 1'b0,8'h00};
    vecs[3]  = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b100,2'b00,2'd1, 1'b0,8'h00};
    vecs[4]  = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[5]  = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[6]  = '{1'b0,2'b00,2'b00,1'b0,1'b1,8'h77, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[7]  = '{1'b0,2'b00,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b01,2'd1, 1'b1,8'h77};
    vecs[8]  = '{1'b0,2'b00,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b1,8'h77};
    // read by requester 1 returning 3C; stray sm_done outside WAIT ignored
    vecs[9]  = '{1'b0,2'b10,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b10,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[10] = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b010,2'b00,2'd2, 1'b0,8'h00};
    vecs[11] = '{1'b0,2'b00,2'b00,1'b0,1'b1,8'h3C, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[12] = '{1'b0,2'b00,2'b00,1'b0,1'b1,8'hFF, 1'b1, 2'b00,3'b000,2'b10,2'd2, 1'b1,8'h3C};
    vecs[13] = '{1'b0,2'b00,2'b00,1'b1,1'b1,8'hEE, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b1,8'h3C};
    vecs[14] = '{1'b0,2'b00,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b1,8'h3C};
    // reset, then both requesters hold reads: grants 0,1,0,1
    vecs[15] = '{1'b1,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b0, 2'b00,3'b000,2'b00,2'd0, 1'b0,8'h00};
    vecs[16] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b01,3'b000,2'b00,2'd0, 1'b1,8'h00};
    vecs[17] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b010,2'b00,2'd1, 1'b0,8'h00};
    vecs[18] = '{1'b0,2'b11,2'b00,1'b1,1'b1,8'h11, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[19] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b01,2'd1, 1'b1,8'h11};
    vecs[20] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b10,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[21] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b010,2'b00,2'd2, 1'b0,8'h00};
    vecs[22] = '{1'b0,2'b11,2'b00,1'b1,1'b1,8'h22, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[23] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b10,2'd2, 1'b1,8'h22};
    vecs[24] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b01,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[25] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b010,2'b00,2'd1, 1'b0,8'h00};
    vecs[26] = '{1'b0,2'b11,2'b00,1'b1,1'b1,8'h33, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[27] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b01,2'd1, 1'b1,8'h33};
    vecs[28] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b10,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[29] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b010,2'b00,2'd2, 1'b0,8'h00};
    vecs[30] = '{1'b0,2'b11,2'b00,1'b1,1'b1,8'h44, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[31] = '{1'b0,2'b11,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b10,2'd2, 1'b1,8'h44};
    // write by requester 0, reset during WAIT, late sm_done, then a fresh write by 1
    vecs[32] = '{1'b0,2'b01,2'b01,1'b1,1'b0,8'h00, 1'b1, 2'b01,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[33] = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b100,2'b00,2'd1, 1'b0,8'h00};
    vecs[34] = '{1'b1,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd1, 1'b0,8'h00};
    vecs[35] = '{1'b0,2'b00,2'b00,1'b0,1'b1,8'h55, 1'b1, 2'b00,3'b000,2'b00,2'd0, 1'b1,8'h00};
    vecs[36] = '{1'b0,2'b10,2'b10,1'b1,1'b0,8'h00, 1'b1, 2'b10,3'b000,2'b00,2'd0, 1'b1,8'h00};
    vecs[37] = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b100,2'b00,2'd2, 1'b0,8'h00};
    vecs[38] = '{1'b0,2'b00,2'b00,1'b0,1'b1,8'h99, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[39] = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b10,2'd2, 1'b1,8'h99};
    vecs[40] = '{1'b0,2'b00,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b1,8'h99};
    // request withdrawn while sm_ready is low: no grant, fields untouched
    vecs[41] = '{1'b0,2'b01,2'b00,1'b0,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[42] = '{1'b0,2'b00,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b0,8'h00};
    vecs[43] = '{1'b0,2'b00,2'b00,1'b1,1'b0,8'h00, 1'b1, 2'b00,3'b000,2'b00,2'd2, 1'b1,8'h99};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      RESET     = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_write = vecs[i].wr;
      sm_ready  = vecs[i].rdy;
      sm_done   = vecs[i].done;
      sm_rdata  = vecs[i].rdata;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("ctl[%0d]", i),
              64'({req_ready, WRITE, READ, REF, rsp_valid, ref_pending, ref_overrun}),
              64'({vecs[i].e_rr, vecs[i].e_stb, vecs[i].e_rsp, 2'b00}));
        check($sformatf("fields[%0d]", i),
              64'({Addr_Row, Addr_Column, BA_in, Data_input}),
              64'(exp_fields(vecs[i].e_fld)));
        if (vecs[i].e_chkd) begin
          check($sformatf("rdata[%0d]", i), 64'(rsp_rdata), 64'(vecs[i].e_rdata));
        end
      end
    end

    // Refresh priority: pending rises while requester 0 is in flight and
    // requester 1 waits; REF goes first and yields no response.
    apply_idle_reset();
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      RESET     = 1'b0;
      req_valid = (t == 1) ? 2'b11 : 2'b10;
      req_write = 2'b00;
      sm_ready  = 1'b1;
      sm_done   = (t == 18) || (t == 22);
      sm_rdata  = 8'h00;
      #1;
      if (t == 1)  check("prio_grant0",     64'(f_req_ready), 64'(2'b01));
      if (t == 16) check("prio_pend_pre",   64'(f_ref_pending), 64'(1'b0));
      if (t == 17) check("prio_pend_rise",  64'(f_ref_pending), 64'(1'b1));
      if (t == 19) check("prio_rsp0",       64'(f_rsp_valid), 64'(2'b01));
      if (t == 20) check("prio_no_grant",   64'({f_req_ready, f_REF}), 64'({2'b00, 1'b0}));
      if (t == 21) check("prio_ref_strobe", 64'({f_WRITE, f_READ, f_REF, f_ref_pending}), 64'(4'b0011));
      if (t == 22) check("prio_pend_clr",   64'(f_ref_pending), 64'(1'b0));
      if (t == 23) check("prio_grant1",     64'({f_req_ready, f_rsp_valid}), 64'({2'b10, 2'b00}));
      if (t == 24) check("prio_read1",      64'({f_READ, f_Addr_Row}), 64'({1'b1, R1_ROW}));
    end

    // Overrun: state machine busy for 40 cycles, then a single REF; later a
    // REF strobe coinciding with an expiry leaves ref_pending set.
    apply_idle_reset();
    ref_cnt = 0;
    for (int t = 1; t <= 68; t++) begin
      @(negedge clk);
      RESET     = 1'b0;
      req_valid = 2'b00;
      req_write = 2'b00;
      sm_ready  = ((t >= 41) && (t <= 44)) || (t >= 63);
      sm_done   = (t == 43) || (t == 65);
      sm_rdata  = 8'h00;
      #1;
      if ((t >= 41) && (t <= 62) && f_REF) ref_cnt++;
      if (t == 32) check("ovr_not_yet",   64'(f_ref_overrun), 64'(1'b0));
      if (t == 33) check("ovr_set",       64'(f_ref_overrun), 64'(1'b1));
      if (t == 40) check("ovr_hold",      64'({f_ref_overrun, f_ref_pending, f_REF}), 64'(3'b110));
      if (t == 42) check("ovr_ref",       64'(f_REF), 64'(1'b1));
      if (t == 43) check("ovr_pend_clr",  64'(f_ref_pending), 64'(1'b0));
      if (t == 49) check("ovr_pend_again",64'(f_ref_pending), 64'(1'b1));
      if (t == 62) check("ovr_ref_count", 64'(ref_cnt), 64'(1));
      if (t == 64) check("setwin_ref",    64'(f_REF), 64'(1'b1));
      if (t == 65) check("setwin_pend",   64'(f_ref_pending), 64'(1'b1));
      if (t == 67) check("setwin_ref2",   64'({f_REF, f_rsp_valid}), 64'({1'b1, 2'b00}));
      if (t == 68) check("setwin_final",  64'({f_ref_pending, f_ref_overrun}), 64'(2'b01));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
